// File: rtl/vga_coord_gen.sv
// ---------------------------------------------------------------------------
// vga_coord_gen
//
// Free-running VGA raster timing generator. Two cascaded counters walk the
// raster (column, then row); sync, active-video and frame-start decodes are
// computed from the *next* coordinate values so that they are registered in
// the same cycle as the coordinates they describe.
//
// Optional build macro: VGA_PIPE_ALIGN_EN
//   When defined, VGA_hsync / VGA_vsync / VGA_active pass through one extra
//   register stage (loaded only on enabled edges) so they lag the
//   coordinates by one enabled cycle, lining up with a registered pixel
//   compositor. Coordinates, frameStart and frameCount are unaffected.
//
// Ports:
//   CLK             in   pixel clock
//   RESET           in   synchronous, active-high reset (priority over enable)
//   PIXEL_EN        in   raster advances only on edges where this is high
//   VGA_horzCoord   out  12-bit column, 0..H_TOTAL-1
//   VGA_vertCoord   out  12-bit row,    0..V_TOTAL-1
//   VGA_active      out  column < H_ACTIVE and row < V_ACTIVE
//   VGA_hsync       out  horizontal sync, active level H_POL
//   VGA_vsync       out  vertical sync, active level V_POL
//   VGA_frameStart  out  high while coordinates are (0,0)
//   VGA_frameCount  out  completed-frame counter, wraps modulo 2^16
// ---------------------------------------------------------------------------
module vga_coord_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 48,
    parameter int H_SYNC   = 112,
    parameter int H_BP     = 248,
    parameter int V_ACTIVE = 1024,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 38,
    parameter int H_POL    = 1,
    parameter int V_POL    = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PIXEL_EN,
    output logic [11:0] VGA_horzCoord,
    output logic [11:0] VGA_vertCoord,
    output logic        VGA_active,
    output logic        VGA_hsync,
    output logic        VGA_vsync,
    output logic        VGA_frameStart,
    output logic [15:0] VGA_frameCount
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

    // 13-bit compare constants so an active width of exactly 4096 still works
    localparam logic [12:0] H_ACTIVE_C = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACTIVE_C = 13'(V_ACTIVE);
    localparam logic [12:0] HS_FIRST_C = 13'(HS_FIRST);
    localparam logic [12:0] HS_LAST_C  = 13'(HS_LAST);
    localparam logic [12:0] VS_FIRST_C = 13'(VS_FIRST);
    localparam logic [12:0] VS_LAST_C  = 13'(VS_LAST);
    localparam logic [11:0] H_LAST_C   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST_C   = 12'(V_TOTAL - 1);

    localparam logic H_POL_L = (H_POL != 0);
    localparam logic V_POL_L = (V_POL != 0);

    // Elaboration-time guards: coordinates are 12 bits wide, and an empty
    // sync window would make the inclusive range bounds meaningless.
    if (H_TOTAL > 4096) begin : gHTotalCheck
        $error("vga_coord_gen: H_TOTAL exceeds 4096");
    end
    if (V_TOTAL > 4096) begin : gVTotalCheck
        $error("vga_coord_gen: V_TOTAL exceeds 4096");
    end
    if ((H_SYNC < 1) || (V_SYNC < 1)) begin : gSyncCheck
        $error("vga_coord_gen: sync widths must be at least 1");
    end

    logic [11:0] horzCount_r;
    logic [11:0] vertCount_r;
    logic [15:0] frameCount_r;
    logic        activeDec_r;
    logic        hsyncDec_r;
    logic        vsyncDec_r;
    logic        frameStart_r;

    logic [11:0] horzNext_s;
    logic [11:0] vertNext_s;
    logic        frameWrap_s;
    logic        activeNext_s;
    logic        hsyncNext_s;
    logic        vsyncNext_s;
    logic        frameStartNext_s;

    // Next raster position: column wraps at H_TOTAL-1, row steps on column wrap
    always_comb begin
        horzNext_s  = horzCount_r;
        vertNext_s  = vertCount_r;
        frameWrap_s = 1'b0;
        if (horzCount_r == H_LAST_C) begin
            horzNext_s = 12'd0;
            if (vertCount_r == V_LAST_C) begin
                vertNext_s  = 12'd0;
                frameWrap_s = 1'b1;
            end else begin
                vertNext_s = vertCount_r + 12'd1;
            end
        end else begin
            horzNext_s = horzCount_r + 12'd1;
        end
    end

    // Decodes of the next position, so they register alongside the coordinates
    always_comb begin
        activeNext_s     = ({1'b0, horzNext_s} < H_ACTIVE_C) &&
                           ({1'b0, vertNext_s} < V_ACTIVE_C);
        hsyncNext_s      = (({1'b0, horzNext_s} >= HS_FIRST_C) &&
                            ({1'b0, horzNext_s} <= HS_LAST_C)) ? H_POL_L : ~H_POL_L;
        vsyncNext_s      = (({1'b0, vertNext_s} >= VS_FIRST_C) &&
                            ({1'b0, vertNext_s} <= VS_LAST_C)) ? V_POL_L : ~V_POL_L;
        frameStartNext_s = (horzNext_s == 12'd0) && (vertNext_s == 12'd0);
    end

    // Raster counters, frame counter and coordinate-aligned decode registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            horzCount_r  <= 12'd0;
            vertCount_r  <= 12'd0;
            frameCount_r <= 16'd0;
            activeDec_r  <= 1'b1;
            hsyncDec_r   <= ~H_POL_L;
            vsyncDec_r   <= ~V_POL_L;
            frameStart_r <= 1'b1;
        end else if (PIXEL_EN) begin
            horzCount_r  <= horzNext_s;
            vertCount_r  <= vertNext_s;
            frameCount_r <= frameWrap_s ? (frameCount_r + 16'd1) : frameCount_r;
            activeDec_r  <= activeNext_s;
            hsyncDec_r   <= hsyncNext_s;
            vsyncDec_r   <= vsyncNext_s;
            frameStart_r <= frameStartNext_s;
        end
    end

    assign VGA_horzCoord  = horzCount_r;
    assign VGA_vertCoord  = vertCount_r;
    assign VGA_frameCount = frameCount_r;
    assign VGA_frameStart = frameStart_r;

`ifdef VGA_PIPE_ALIGN_EN
    logic activePipe_r;
    logic hsyncPipe_r;
    logic vsyncPipe_r;

    // Extra alignment stage: decodes lag the coordinates by one enabled cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            activePipe_r <= 1'b1;
            hsyncPipe_r  <= ~H_POL_L;
            vsyncPipe_r  <= ~V_POL_L;
        end else if (PIXEL_EN) begin
            activePipe_r <= activeDec_r;
            hsyncPipe_r  <= hsyncDec_r;
            vsyncPipe_r  <= vsyncDec_r;
        end
    end

    assign VGA_active = activePipe_r;
    assign VGA_hsync  = hsyncPipe_r;
    assign VGA_vsync  = vsyncPipe_r;
`else
    assign VGA_active = activeDec_r;
    assign VGA_hsync  = hsyncDec_r;
    assign VGA_vsync  = vsyncDec_r;
`endif

endmodule

// File: tb/tb_vga_coord_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_coord_gen
//
// Directed bench for vga_coord_gen using a reduced raster (32 x 14) so whole
// frames are cheap: H = 20 active + 3 fp + 4 sync + 5 bp, hsync on 23..26;
// V = 8 active + 1 fp + 2 sync + 3 bp, vsync on rows 9..10.
// A small coordinate model tracks the expected raster position; directed
// steps additionally compare against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_vga_coord_gen;

    localparam int HA = 20;
    localparam int HF = 3;
    localparam int HS = 4;
    localparam int HB = 5;
    localparam int HT = HA + HF + HS + HB;   // 32
    localparam int VA = 8;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VT = VA + VF + VS + VB;   // 14

`ifdef VGA_PIPE_ALIGN_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        PIXEL_EN = 1'b1;
    logic [11:0] VGA_horzCoord;
    logic [11:0] VGA_vertCoord;
    logic        VGA_active;
    logic        VGA_hsync;
    logic        VGA_vsync;
    logic        VGA_frameStart;
    logic [15:0] VGA_frameCount;

    int checks = 0;
    int failures = 0;

    // expected raster state
    int   mH = 0;
    int   mV = 0;
    int   mFc = 0;
    logic pAct = 1'b1;
    logic pHs = 1'b0;
    logic pVs = 1'b0;
    int   vsSeen = 0;

    vga_coord_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1), .V_POL(1)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .PIXEL_EN(PIXEL_EN),
        .VGA_horzCoord(VGA_horzCoord),
        .VGA_vertCoord(VGA_vertCoord),
        .VGA_active(VGA_active),
        .VGA_hsync(VGA_hsync),
        .VGA_vsync(VGA_vsync),
        .VGA_frameStart(VGA_frameStart),
        .VGA_frameCount(VGA_frameCount)
    );

    always #5 CLK = ~CLK;

    function automatic logic decAct(input int h, input int v);
        return (h < HA) && (v < VA);
    endfunction

    function automatic logic decHs(input int h);
        return (h >= 23) && (h <= 26);
    endfunction

    function automatic logic decVs(input int v);
        return (v >= 9) && (v <= 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        logic eAct;
        logic eHs;
        logic eVs;
        eAct = (PIPE != 0) ? pAct : decAct(mH, mV);
        eHs  = (PIPE != 0) ? pHs  : decHs(mH);
        eVs  = (PIPE != 0) ? pVs  : decVs(mV);
        chk("model_horz", VGA_horzCoord, mH);
        chk("model_vert", VGA_vertCoord, mV);
        chk("model_active", VGA_active, eAct);
        chk("model_hsync", VGA_hsync, eHs);
        chk("model_vsync", VGA_vsync, eVs);
        chk("model_frameStart", VGA_frameStart, (mH == 0) && (mV == 0));
        chk("model_frameCount", VGA_frameCount, mFc);
    endtask

    // one clock edge with the given enable/reset, then model update and check
    task automatic tick(input logic en, input logic rst);
        PIXEL_EN = en;
        RESET    = rst;
        @(posedge CLK);
        #1;
        if (rst) begin
            mH = 0; mV = 0; mFc = 0;
            pAct = 1'b1; pHs = 1'b0; pVs = 1'b0;
        end else if (en) begin
            pAct = decAct(mH, mV);
            pHs  = decHs(mH);
            pVs  = decVs(mV);
            if (mH == HT - 1) begin
                mH = 0;
                if (mV == VT - 1) begin
                    mV = 0;
                    mFc = (mFc + 1) % 65536;
                end else begin
                    mV++;
                end
            end else begin
                mH++;
            end
        end
        if (VGA_vsync === 1'b1) vsSeen++;
        checkAll();
    endtask

    task automatic runTo(input int h, input int v, input int fc);
        for (int i = 0; i < 8000 && !(mH == h && mV == v && mFc == fc); i++)
            tick(1'b1, 1'b0);
        chk("runTo_horz", VGA_horzCoord, h);
        chk("runTo_vert", VGA_vertCoord, v);
        chk("runTo_frameCount", VGA_frameCount, fc);
    endtask

    initial begin
        int hsCount;
        int hsFirst;
        int hsLast;

        // reset held for three enabled edges
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        chk("rst_horz", VGA_horzCoord, 0);
        chk("rst_vert", VGA_vertCoord, 0);
        chk("rst_active", VGA_active, 1);
        chk("rst_frameStart", VGA_frameStart, 1);
        chk("rst_hsync", VGA_hsync, 0);
        chk("rst_vsync", VGA_vsync, 0);
        chk("rst_frameCount", VGA_frameCount, 0);

        // line wrap from the last column of row 0
        runTo(31, 0, 0);
        chk("eol_active", VGA_active, 0);
        tick(1'b1, 1'b0);
        chk("wrap_horz", VGA_horzCoord, 0);
        chk("wrap_vert", VGA_vertCoord, 1);
        chk("wrap_frameStart", VGA_frameStart, 0);
        chk("wrap_active", VGA_active, (PIPE != 0) ? 0 : 1);

        // hsync window on line 5
        runTo(0, 5, 0);
        vsSeen  = 0;
        hsCount = 0;
        hsFirst = -1;
        hsLast  = -1;
        for (int i = 0; i < HT; i++) begin
            if (i > 0) tick(1'b1, 1'b0);
            if (VGA_hsync === 1'b1) begin
                hsCount++;
                if (hsFirst < 0) hsFirst = mH;
                hsLast = mH;
            end
        end
        chk("hs_count", hsCount, 4);
        chk("hs_first", hsFirst, 23 + PIPE);
        chk("hs_last", hsLast, 26 + PIPE);

        // frame wrap, vsync covers exactly two whole lines
        runTo(31, 13, 0);
        chk("vs_cycles", vsSeen, 2 * HT);
        tick(1'b1, 1'b0);
        chk("fw_horz", VGA_horzCoord, 0);
        chk("fw_vert", VGA_vertCoord, 0);
        chk("fw_frameStart", VGA_frameStart, 1);
        chk("fw_frameCount", VGA_frameCount, 1);

        // frameStart holds while disabled
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("hold_frameStart", VGA_frameStart, 1);
        chk("hold_horz", VGA_horzCoord, 0);

        // enable gating 1,0,0,1 from (10,3)
        runTo(10, 3, 1);
        tick(1'b1, 1'b0);
        chk("gate1_horz", VGA_horzCoord, 11);
        tick(1'b0, 1'b0);
        chk("gate2_horz", VGA_horzCoord, 11);
        tick(1'b0, 1'b0);
        chk("gate3_horz", VGA_horzCoord, 11);
        tick(1'b1, 1'b0);
        chk("gate4_horz", VGA_horzCoord, 12);
        chk("gate4_vert", VGA_vertCoord, 3);

        // reset mid-frame with frameCount = 7
        runTo(17, 6, 7);
        tick(1'b1, 1'b1);
        chk("mrst_horz", VGA_horzCoord, 0);
        chk("mrst_vert", VGA_vertCoord, 0);
        chk("mrst_frameCount", VGA_frameCount, 0);
        chk("mrst_frameStart", VGA_frameStart, 1);
        chk("mrst_active", VGA_active, 1);

        // active lag relative to coordinates at the first blanking column
        runTo(20, 0, 0);
        chk("lag_active_at20", VGA_active, PIPE);
        tick(1'b1, 1'b0);
        chk("lag_active_at21", VGA_active, 0);

        // reset wins over a low enable
        runTo(5, 2, 0);
        tick(1'b0, 1'b1);
        chk("rst_noen_horz", VGA_horzCoord, 0);
        chk("rst_noen_vert", VGA_vertCoord, 0);
        chk("rst_noen_frameStart", VGA_frameStart, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_coord_gen.md
Name: vga_coord_gen

Overview:
- Free-running VGA raster timing generator.
- Produces the `VGA_horzCoord`/`VGA_vertCoord` pixel coordinates consumed by the glyph and condition decoders (digit/character drawing blocks), plus sync, active-video and frame markers for the display output stage.
- Sits directly upstream of every coordinate-driven drawing block in the oscilloscope display path.
- Defaults target 1280x1024@60 Hz with a 108 MHz pixel clock.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 48, horizontal front porch (pixels)
- H_SYNC, 112, horizontal sync width (pixels)
- H_BP, 248, horizontal back porch (pixels)
- V_ACTIVE, 1024, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BP, 38, vertical back porch (lines)
- H_POL, 1, hsync active level (1 = active high)
- V_POL, 1, vsync active level (1 = active high)

Ports:
- CLK  input  1  pixel clock
- RESET  input  1  synchronous, active-high reset
- PIXEL_EN  input  1  count enable; the raster advances only on edges where it is high
- VGA_horzCoord  output  12  current column, 0..H_TOTAL-1
- VGA_vertCoord  output  12  current row, 0..V_TOTAL-1
- VGA_active  output  1  high when column < H_ACTIVE and row < V_ACTIVE
- VGA_hsync  output  1  horizontal sync, level per H_POL
- VGA_vsync  output  1  vertical sync, level per V_POL
- VGA_frameStart  output  1  one-enabled-cycle pulse at coordinate (0,0)
- VGA_frameCount  output  16  completed-frame counter, wraps modulo 2^16

Behaviour:
- Interface (decided): single clock `CLK`; `RESET` is synchronous and active-high. All outputs are registered.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1688); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 1066).
- Reset (edge with `RESET` high) forces:
  - coords = (0,0)
  - VGA_active = 1
  - VGA_frameStart = 1
  - VGA_hsync = !H_POL, VGA_vsync = !V_POL
  - VGA_frameCount = 0
- Reset has priority over `PIXEL_EN`. Reset asserted mid-frame returns to (0,0) on the next edge, with no partial-frame increment of VGA_frameCount.
- Edge with `PIXEL_EN` high and no reset:
  - horz = horz+1; at H_TOTAL-1, horz wraps to 0 and vert increments.
  - vert wraps to 0 when horz wraps at vert = V_TOTAL-1.
  - VGA_frameCount increments, modulo 2^16, on that same edge.
- Edge with `PIXEL_EN` low: every output holds its value, including VGA_frameStart.
- Decodes are computed from the next coordinate values, so sync, active and frameStart are valid in the same cycle as the coordinates they describe (zero relative latency):
  - VGA_hsync = H_POL when horz in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], default 1328..1439; otherwise !H_POL.
  - VGA_vsync = V_POL when vert in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], default 1025..1027, for whole lines; otherwise !V_POL.
  - VGA_frameStart = 1 exactly when the coordinates are (0,0).
- Width rule: both coordinates are 12 bits. H_TOTAL and V_TOTAL must be ≤ 4096, enforced by an elaboration-time check.
- No other states exist; the block is a two-counter raster with no illegal states.

Optional Feature:
- Macro: `VGA_PIPE_ALIGN_EN`.
- When defined: VGA_hsync, VGA_vsync and VGA_active pass through one extra register stage, lagging the coordinates by one enabled cycle. This matches the registered pixel compositor fed by the condition decoders.
  - The extra stage loads only when `PIXEL_EN` is high.
  - Its reset values equal the non-pipelined reset values.
- When undefined: zero relative latency, as specified above.
- Coordinates, VGA_frameStart and VGA_frameCount are unaffected either way.

Test Plan:
- Reset: hold `RESET` high for 3 cycles with `PIXEL_EN`=1 → coords (0,0), active=1, frameStart=1, hsync=0, vsync=0, frameCount=0.
- Line wrap: run to horz=1687, vert=0, then one enabled edge → (0,1), frameStart=0; active=0 at horz=1280, back to 1 at horz=0.
- Hsync window: scan line 5 → hsync=1 for exactly horz 1328..1439 (112 cycles), 0 at 1327 and 1440.
- Frame wrap: from (1687,1065), one enabled edge → (0,0), frameStart=1, frameCount 0→1; vsync=1 only on rows 1025..1027.
- Enable gating: toggle `PIXEL_EN` 1,0,0,1 starting at (10,3) → (11,3), (11,3), (11,3), (12,3); outputs frozen while low.
- Reset mid-frame: assert `RESET` at (700,500) with frameCount=7 → next edge (0,0), frameCount=0; with `VGA_PIPE_ALIGN_EN` defined, active/hsync lag coords by exactly one enabled cycle.
